sa_fifo_ctrl_32x32: RTL
=======================

SA_FIFO_CTRL_32X32 -- requirements
Module: sa_fifo_ctrl_32x32

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 wr_pvld  input  1  write data valid.
REQ-005 wr_prdy  output  1  FIFO can accept a word; depends only on registered state.
REQ-006 wr_pd  input  32  write payload.
REQ-007 rd_pvld  output  1  read data valid.
REQ-008 rd_prdy  input  1  consumer accepts the word.
REQ-009 rd_pd  output  32  read payload, taken directly from the RAM output register.
REQ-010 pwrbus_ram_pd  input  32  RAM power-down bus, passed unmodified to the RAM instance.
REQ-011 fifo_count  output  6  occupancy 0..32; present only under SA_FIFO_CTRL_OCCUPANCY_EN.

Function
REQ-012 Depth SHALL be 32 words of 32 bits, stored in one sa_ram_rwsp_32x32 instance: 2-cycle read, re then ore.
REQ-013 Push SHALL occur when wr_pvld && wr_prdy: we=1, wa=wr_ptr, di=wr_pd; wr_ptr increments mod 32 (wraps 31->0).
REQ-014 wr_prdy SHALL equal (count != 32); a push is refused at full even if a pop occurs in the same cycle.
REQ-015 count SHALL increment on push, decrement on pop (rd_pvld && rd_prdy), and stay unchanged on simultaneous push and pop.
REQ-016 The read pipeline SHALL have three stages: S1 valid (re issued), S2 valid (ore issued, data in RAM dout register), and pop.
REQ-017 unread = words written but not yet issued to S1; a 6-bit counter of that value SHALL increment on push and decrement on re.
REQ-018 re SHALL assert with ra=rd_ptr when unread != 0 and (S1 empty or S1 advancing); rd_ptr increments mod 32 on re.
REQ-019 S1 advances and ore asserts when S1 valid and (S2 empty or pop this cycle).
REQ-020 rd_pvld SHALL equal S2 valid; rd_pd SHALL hold stable while rd_pvld && !rd_prdy.
REQ-021 Latency from an accepted push into an empty FIFO to rd_pvld SHALL be exactly 3 cycles: push at T, re at T+1, ore at T+2, rd_pvld at T+3.
REQ-022 Sustained throughput SHALL be 1 word/cycle when wr_pvld=1 and rd_prdy=1.
REQ-023 A RAM entry SHALL NOT be overwritten before its pop, guaranteed by REQ-014 counting pipeline-resident words.
REQ-024 Read order SHALL equal write order across pointer wrap-around.

Reset
REQ-025 On rst: wr_ptr=0, rd_ptr=0, count=0, unread=0, S1=0, S2=0.
REQ-026 During rst, the outputs SHALL be wr_prdy=0, rd_pvld=0 and fifo_count=0.
REQ-027 wr_prdy SHALL go to 1 in the first cycle after rst deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight and stored words; RAM contents are not cleared.
REQ-029 rd_pd value is don't-care while rd_pvld=0.
REQ-030 we, re and ore SHALL be 0 while rst=1.

Configuration
REQ-031 SA_FIFO_CTRL_OCCUPANCY_EN defined: fifo_count port exists and equals count, registered.
REQ-032 SA_FIFO_CTRL_OCCUPANCY_EN undefined: no fifo_count port; all other behaviour is identical.

Structure
REQ-033 The shared package sa_fifo_pkg SHALL hold SA_FIFO_DEPTH=32, SA_FIFO_AW=5, SA_FIFO_DW=32 and SA_FIFO_CW=6.
REQ-034 The block SHALL contain exactly one sub-module, sa_ram_rwsp_32x32.
REQ-035 All control logic (pointers, counters, S1/S2 valids) SHALL be local to sa_fifo_ctrl_32x32.

Verification
REQ-036 Single word: push 0xDEADBEEF at T into an empty FIFO with rd_prdy=1 -> rd_pvld=1, rd_pd=0xDEADBEEF at T+3, count back to 0 at T+4.
REQ-037 Fill: 32 pushes of 0..31 with rd_prdy=0 -> wr_prdy=0 after the 32nd; a 33rd wr_pvld is not accepted; fifo_count=32.
REQ-038 Backpressure: full FIFO, rd_prdy held 0 for 10 cycles -> rd_pd=0 stable; then rd_prdy=1 -> pops 0..31 in order, one per cycle.
REQ-039 Wrap: stream 100 incrementing words with wr_pvld=1 and rd_prdy toggling 1/0 -> output equals the input sequence; no loss or duplication past ptr 31->0.
REQ-040 Simultaneous events: count=5 with push and pop in the same cycle -> count stays 5; at count=32 with push and pop -> push refused, count=31.
REQ-041 Mid-operation reset: rst pulse with 3 words in S1/S2/unread -> next cycle rd_pvld=0, count=0; a new push 0x1 appears at +3 cycles.

Source files
------------

// File: rtl/sa_fifo_pkg.sv
// Shared geometry and types for the 32x32 FIFO controller and its RAM.
package sa_fifo_pkg;
    localparam int SA_FIFO_DEPTH = 32;
    localparam int SA_FIFO_AW    = 5;
    localparam int SA_FIFO_DW    = 32;
    localparam int SA_FIFO_CW    = 6;

    typedef logic [SA_FIFO_AW-1:0] addr_t;
    typedef logic [SA_FIFO_DW-1:0] data_t;
    typedef logic [SA_FIFO_CW-1:0] cnt_t;

    localparam cnt_t SA_FIFO_FULL = cnt_t'(SA_FIFO_DEPTH);
endpackage

// File: rtl/sa_ram_rwsp_32x32.sv
// 32x32 single-port-per-direction RAM: write in one cycle, read in two (re latches the array, ore loads dout).
// No reset: contents and output register survive controller reset; dout holds while ore is low.
module sa_ram_rwsp_32x32
    import sa_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  re,
    input  logic [SA_FIFO_AW-1:0] ra,
    input  logic                  we,
    input  logic [SA_FIFO_AW-1:0] wa,
    input  logic [SA_FIFO_DW-1:0] di,
    input  logic                  ore,
    output logic [SA_FIFO_DW-1:0] dout,
    input  logic [31:0]           pwrbus_ram_pd
);
    data_t mem [SA_FIFO_DEPTH];
    data_t ram_q;

    // Behavioural model has no power states; the bus only reaches the hard macro.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we)  mem[wa] <= di;
        if (re)  ram_q   <= mem[ra];
        if (ore) dout    <= ram_q;
    end
endmodule

// File: rtl/sa_fifo_ctrl_32x32.sv
// 32-deep valid/ready FIFO over a 2-cycle RAM; push-to-rd_pvld latency 3, 1 word/cycle sustained.
// wr_prdy drops when all 32 words (stored or in the read pipe) are held; optional fifo_count under SA_FIFO_CTRL_OCCUPANCY_EN.
module sa_fifo_ctrl_32x32
    import sa_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_pvld,
    output logic                  wr_prdy,
    input  logic [SA_FIFO_DW-1:0] wr_pd,
    output logic                  rd_pvld,
    input  logic                  rd_prdy,
    output logic [SA_FIFO_DW-1:0] rd_pd,
    input  logic [31:0]           pwrbus_ram_pd
`ifdef SA_FIFO_CTRL_OCCUPANCY_EN
    ,output logic [SA_FIFO_CW-1:0] fifo_count
`endif
);
    addr_t wr_ptr, rd_ptr;
    cnt_t  count, unread;
    logic  s1_vld, s2_vld;
    logic  push, pop, re, ore, s1_adv;

    // Reset gating keeps the handshake quiet during the cycle rst is first sampled.
    assign wr_prdy = !rst && (count != SA_FIFO_FULL);
    assign rd_pvld = !rst && s2_vld;
    assign push    = wr_pvld && wr_prdy;
    assign pop     = rd_pvld && rd_prdy;
    assign s1_adv  = s1_vld && (!s2_vld || pop);
    assign ore     = !rst && s1_adv;
    assign re      = !rst && (unread != '0) && (!s1_vld || s1_adv);

`ifdef SA_FIFO_CTRL_OCCUPANCY_EN
    assign fifo_count = rst ? '0 : count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            unread <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + addr_t'(1);
            if (re)   rd_ptr <= rd_ptr + addr_t'(1);
            count  <= count + cnt_t'(push) - cnt_t'(pop);
            unread <= unread + cnt_t'(push) - cnt_t'(re);
            if (re)          s1_vld <= 1'b1;
            else if (s1_adv) s1_vld <= 1'b0;
            if (ore)         s2_vld <= 1'b1;
            else if (pop)    s2_vld <= 1'b0;
        end
    end

    sa_ram_rwsp_32x32 u_ram (
        .clk           (clk),
        .re            (re),
        .ra            (rd_ptr),
        .we            (push),
        .wa            (wr_ptr),
        .di            (wr_pd),
        .ore           (ore),
        .dout          (rd_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );
endmodule
